dport_regbank: RTL

DPORT_REGBANK -- requirements
Module: dport_regbank

---
 rtl/dport_regbank.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dport_regbank.sv
// dport_regbank: shadow/live attribute bank with control, aux and interrupt registers on a req/ack bus.
// Latency: reg_ack/reg_rdata/reg_err one cycle after reg_req; attr loads from shadow at vblank (or every cycle in immediate mode).
// Backpressure: none; a transfer may be issued every cycle and always completes.
module dport_regbank #(
  parameter int ATTRW = 274,
  parameter int NIRQ  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  input  logic [3:0]       reg_wstrb,
  input  logic             reg_wr,
  input  logic             reg_req,
  output logic [31:0]      reg_rdata,
  output logic             reg_ack,
  output logic             reg_err,
  output logic [ATTRW-1:0] attr,
  output logic [31:0]      phyctl,
  output logic [31:0]      auxctrl,
  input  logic [31:0]      auxstat,
  input  logic             vblank,
  input  logic [NIRQ-1:0]  irq_src,
  output logic             irq
);
  localparam int         NATTR   = (ATTRW + 31) / 32;
  localparam logic [6:0] NATTR_W = 7'(NATTR);

  logic [ATTRW-1:0] shadow_q;
  logic [ATTRW-1:0] shadow_d;
  logic             pend_q;
  logic             imm_q;
  logic [NIRQ-1:0]  irq_stat_q;
  logic [NIRQ-1:0]  irq_en_q;
  logic [NIRQ-1:0]  irq_src_q;
  logic [NIRQ-1:0]  irq_rise;
  logic [NIRQ-1:0]  irq_clr;

  logic [5:0]  widx;
  logic        sel_phy, sel_ctrl, sel_aux, sel_stat, sel_istat, sel_ien, sel_attr;
  logic        addr_ok;
  logic        wr_en;
  logic [31:0] bmask;
  logic [31:0] rd_val;

  // Address decode, byte-lane mask and read mux (reads see pre-write state).
  always_comb begin
    widx      = reg_addr[7:2] - 6'd16;
    sel_phy   = (reg_addr == 8'h00);
    sel_ctrl  = (reg_addr == 8'h04);
    sel_aux   = (reg_addr == 8'h08);
    sel_stat  = (reg_addr == 8'h0C);
    sel_istat = (reg_addr == 8'h10);
    sel_ien   = (reg_addr == 8'h14);
    sel_attr  = (reg_addr[7:6] != 2'b00) && (reg_addr[1:0] == 2'b00) && ({1'b0, widx} < NATTR_W);
    // auxstat is read-only: a write there is an error
    addr_ok   = sel_phy | sel_ctrl | sel_aux | (sel_stat & ~reg_wr) | sel_istat | sel_ien | sel_attr;
    wr_en     = reg_req & reg_wr & addr_ok;
    bmask     = {{8{reg_wstrb[3]}}, {8{reg_wstrb[2]}}, {8{reg_wstrb[1]}}, {8{reg_wstrb[0]}}};
    rd_val    = '0;
    if (sel_phy)   rd_val = phyctl;
    if (sel_ctrl)  rd_val[1:0] = {imm_q, pend_q};
    if (sel_aux)   rd_val = auxctrl;
    if (sel_stat)  rd_val = auxstat;
    if (sel_istat) rd_val[NIRQ-1:0] = irq_stat_q;
    if (sel_ien)   rd_val[NIRQ-1:0] = irq_en_q;
    if (sel_attr) begin
      for (int b = 0; b < ATTRW; b++)
        if (widx == 6'(b / 32)) rd_val[b % 32] = shadow_q[b];
    end
  end

  // Byte-lane merge of a bus write into the shadow attribute words.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && sel_attr) begin
      for (int b = 0; b < ATTRW; b++)
        if (widx == 6'(b / 32) && bmask[b % 32]) shadow_d[b] = reg_wdata[b % 32];
    end
  end

  // Interrupt edge detect and write-one-to-clear mask.
  always_comb begin
    irq_rise = irq_src & ~irq_src_q;
    irq_clr  = '0;
    if (wr_en && sel_istat) irq_clr = reg_wdata[NIRQ-1:0] & bmask[NIRQ-1:0];
  end

  // Bus response: one-cycle delayed ack with registered data/error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_ack   <= 1'b0;
      reg_err   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack   <= reg_req;
      reg_err   <= reg_req & ~addr_ok;
      reg_rdata <= (reg_req && !reg_wr && addr_ok) ? rd_val : '0;
    end
  end

  // phyctl and auxctrl; auxctrl[31] is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phyctl  <= '0;
      auxctrl <= '0;
    end else begin
      if (wr_en && sel_phy) phyctl <= (phyctl & ~bmask) | (reg_wdata & bmask);
      if (wr_en && sel_aux) auxctrl <= ({1'b0, auxctrl[30:0]} & ~bmask) | (reg_wdata & bmask);
      else                  auxctrl[31] <= 1'b0;
    end
  end

  // Commit control: a new request beats the vblank clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      imm_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~vblank) | (wr_en & sel_ctrl & reg_wstrb[0] & reg_wdata[0]);
      if (wr_en && sel_ctrl && reg_wstrb[0]) imm_q <= reg_wdata[1];
    end
  end

  // Shadow register and live attributes (live loads the pre-write shadow).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      attr     <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (imm_q || (vblank && pend_q)) attr <= shadow_q;
    end
  end

  // Interrupt status/enable; set wins over clear, irq is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_src_q  <= '0;
      irq        <= 1'b0;
    end else begin
      irq_src_q  <= irq_src;
      irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_rise;
      if (wr_en && sel_ien) irq_en_q <= (irq_en_q & ~bmask[NIRQ-1:0]) | (reg_wdata[NIRQ-1:0] & bmask[NIRQ-1:0]);
      irq        <= |(irq_stat_q & irq_en_q);
    end
  end

endmodule
